// File: rtl/memoria_if.sv
// memoria_if: load/store bus between the datapath and the data memory.
// The datapath side (master) drives address, data and controls; the
// memory side (slave) returns registered read data.
interface memoria_if;
  logic [31:0] ad;
  logic [31:0] di;
  logic        we;
  logic        re;
  logic        byte_l;
  logic        byte_s;
  logic [31:0] d_o;

  modport master (
    output ad,
    output di,
    output we,
    output re,
    output byte_l,
    output byte_s,
    input  d_o
  );

  modport slave (
    input  ad,
    input  di,
    input  we,
    input  re,
    input  byte_l,
    input  byte_s,
    output d_o
  );
endinterface

// File: rtl/memoria.sv
// memoria: 256 x 32-bit byte-addressed data memory.
// Synchronous write with optional low-byte store and a registered read
// with optional zero-extended low-byte load. A same-edge read and write
// to one word returns the old contents. Reset clears the whole array and
// the read register asynchronously.
module memoria (
  input  logic     clk,
  input  logic     rst,
  memoria_if.slave bus
);

  logic [31:0] mem_r [0:255];
  logic [31:0] d_o_r;
  logic [7:0]  idx_s;
  logic [31:0] cur_word_s;
  logic [31:0] wr_word_s;
  logic [31:0] rd_word_s;
  logic        ad_unused_s;

  // Merge store data into the current word: byte stores keep the upper 24 bits.
  function automatic logic [31:0] store_merge(
    input logic [31:0] old_word,
    input logic [31:0] wdata,
    input logic        byte_store
  );
    logic [31:0] res;
    if (byte_store) begin
      res = {old_word[31:8], wdata[7:0]};
    end else begin
      res = wdata;
    end
    return res;
  endfunction

  // Shape the load result: byte loads return the zero-extended low byte.
  function automatic logic [31:0] load_extract(
    input logic [31:0] word,
    input logic        byte_load
  );
    logic [31:0] res;
    if (byte_load) begin
      res = {24'h00_0000, word[7:0]};
    end else begin
      res = word;
    end
    return res;
  endfunction

  // Word index; low two bits and bits above 9 do not select storage.
  assign idx_s       = bus.ad[9:2];
  assign ad_unused_s = ^{bus.ad[31:10], bus.ad[1:0]};
  assign cur_word_s  = mem_r[idx_s];

  // Compute the word to be written and the value to be loaded this cycle.
  always_comb begin
    wr_word_s = 32'h0000_0000;
    rd_word_s = 32'h0000_0000;
    wr_word_s = store_merge(cur_word_s, bus.di, bus.byte_s);
    rd_word_s = load_extract(cur_word_s, bus.byte_l);
  end

  // Storage array: cleared on reset, updated on enabled writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) begin
        mem_r[i] <= 32'h0000_0000;
      end
    end else if (bus.we) begin
      mem_r[idx_s] <= wr_word_s;
    end
  end

  // Read register: captures pre-write contents, holds when re is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d_o_r <= 32'h0000_0000;
    end else if (bus.re) begin
      d_o_r <= rd_word_s;
    end
  end

  assign bus.d_o = d_o_r;

endmodule

// File: tb/tb_memoria.sv
// tb_memoria: directed plan plus randomized traffic against a word-array
// reference model of the data memory.
module tb_memoria;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  memoria_if bus ();

  memoria dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference model: plain array of words and the last loaded value.
  logic [31:0] model_mem [0:255];
  logic [31:0] model_dout;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 256; i++) model_mem[i] = 32'h0;
    model_dout = 32'h0;
  endtask

  // One clock cycle of access; called at posedge+1, returns at posedge+1.
  task automatic access(input string tag, input logic [31:0] ad, input logic [31:0] di,
                        input logic we, input logic re, input logic bl, input logic bs);
    logic [31:0] old_w;
    int          w;
    bus.ad = ad; bus.di = di; bus.we = we; bus.re = re;
    bus.byte_l = bl; bus.byte_s = bs;
    @(posedge clk);
    w     = int'(ad[9:2]);
    old_w = model_mem[w];
    if (re) model_dout = bl ? (old_w & 32'h0000_00FF) : old_w;
    if (we) model_mem[w] = bs ? ((old_w & 32'hFFFF_FF00) | (di & 32'h0000_00FF)) : di;
    #1;
    check(tag, bus.d_o, model_dout);
  endtask

  initial begin
    logic [31:0] ad;
    n_tests = 0;
    n_fail  = 0;
    bus.ad = 32'h0; bus.di = 32'h0; bus.we = 1'b0; bus.re = 1'b0;
    bus.byte_l = 1'b0; bus.byte_s = 1'b0;
    rst = 1'b1;
    model_clear();
    #1;
    check("reset_dout", bus.d_o, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Full-word write then read
    access("wr8",      32'd8,  32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0, 1'b0);
    access("rd8",      32'd8,  32'h0,         1'b0, 1'b1, 1'b0, 1'b0);
    check("rd8_const", bus.d_o, 32'h7FFF_FFFF);
    // Byte store
    access("bs8",      32'd8,  32'h0,         1'b1, 1'b0, 1'b0, 1'b1);
    access("rd8b",     32'd8,  32'h0,         1'b0, 1'b1, 1'b0, 1'b0);
    check("bs8_const", bus.d_o, 32'h7FFF_FF00);
    // Byte load
    access("wr20",     32'd20, 32'hAAAA_AAAA, 1'b1, 1'b0, 1'b0, 1'b0);
    access("rd20",     32'd20, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0);
    check("rd20_const", bus.d_o, 32'hAAAA_AAAA);
    access("rd20b",    32'd20, 32'h0,         1'b0, 1'b1, 1'b1, 1'b0);
    check("bl20_const", bus.d_o, 32'h0000_00AA);
    // Aliasing
    access("wr4",      32'd4,  32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b0);
    access("rd5",      32'd5,  32'h0,         1'b0, 1'b1, 1'b0, 1'b0);
    access("rd6",      32'd6,  32'h0,         1'b0, 1'b1, 1'b0, 1'b0);
    access("rd7",      32'd7,  32'h0,         1'b0, 1'b1, 1'b0, 1'b0);
    check("alias_const", bus.d_o, 32'h1234_5678);
    access("rd1028",   32'd1028, 32'h0,       1'b0, 1'b1, 1'b0, 1'b0);
    // Read-before-write and hold
    access("rbw12",    32'd12, 32'hDEAD_BEEF, 1'b1, 1'b1, 1'b0, 1'b0);
    check("rbw_const", bus.d_o, 32'h0);
    access("rd12",     32'd12, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0);
    check("rd12_const", bus.d_o, 32'hDEAD_BEEF);
    access("hold_a",   32'd4,  32'h0,         1'b0, 1'b0, 1'b0, 1'b0);
    access("hold_b",   32'd20, 32'h5555_5555, 1'b0, 1'b0, 1'b1, 1'b1);
    check("hold_const", bus.d_o, 32'hDEAD_BEEF);

    // Randomized traffic, biased toward a few words for collisions
    for (int k = 0; k < 1500; k++) begin
      ad = $urandom();
      if ($urandom_range(0, 1) == 0) ad[9:2] = 8'($urandom_range(0, 15));
      access("rand", ad, $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Mid-cycle reset with a write in flight
    access("pre_rst",  32'd12, 32'h0,         1'b0, 1'b1, 1'b0, 1'b0);
    bus.ad = 32'd16; bus.di = 32'hCAFE_F00D; bus.we = 1'b1; bus.re = 1'b1;
    bus.byte_l = 1'b0; bus.byte_s = 1'b0;
    #2;
    rst = 1'b1;
    model_clear();
    #1;
    check("rst_immediate", bus.d_o, 32'h0);
    @(posedge clk); #1;
    check("rst_held", bus.d_o, 32'h0);
    rst = 1'b0;

    // Sweep after reset: everything reads zero
    for (int i = 0; i < 256; i++) begin
      access("sweep0", 32'(i * 4), 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    // Write word i = i, then sweep again
    for (int i = 0; i < 256; i++) begin
      access("fill", 32'(i * 4), 32'(i), 1'b1, 1'b0, 1'b0, 1'b0);
    end
    for (int i = 0; i < 256; i++) begin
      access("sweep1", 32'(i * 4), 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
      check("sweep1_idx", bus.d_o, 32'(i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
